button_repeat: RTL and testbench

BUTTON_REPEAT -- requirements
Module: button_repeat

---
 rtl/button_repeat_if.sv | 30 +++
 rtl/button_repeat.sv | 132 +++++++++++++
 tb/tb_button_repeat.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/button_repeat_if.sv
// Button event bus: the debounced level goes in, press/release/repeat
// events plus the long-press level and repeat count come back out.
interface button_repeat_if;
   logic       i_level;
   logic       o_press;
   logic       o_release;
   logic       o_repeat;
   logic       o_long;
   logic [7:0] o_rpt_cnt;

   // Side that owns the button level and consumes the events
   modport master (
      output i_level,
      input  o_press,
      input  o_release,
      input  o_repeat,
      input  o_long,
      input  o_rpt_cnt
   );

   // Side that turns the level into events
   modport slave (
      input  i_level,
      output o_press,
      output o_release,
      output o_repeat,
      output o_long,
      output o_rpt_cnt
   );
endinterface

// File: rtl/button_repeat.sv
// Button press / long-press / auto-repeat event generator.
// A press emits o_press. Holding for HOLD_CYC cycles raises o_long and
// emits the first o_repeat. Further o_repeat pulses then follow every
// REPEAT_CYC cycles until release. Every output comes straight from a
// flop, so nothing is combinational from the button level to the outputs.
module button_repeat #(
   parameter int HOLD_CYC   = 12500000,
   parameter int REPEAT_CYC = 2500000,
   parameter int CNT_W      = 24
) (
   input  logic          i_clk,
   input  logic          i_rst,
   button_repeat_if.slave btn
);

   // Reject thresholds the counter cannot represent or that would make the
   // terminal count collide with the entry cycle of a state.
   if (HOLD_CYC < 2 || REPEAT_CYC < 2 ||
       longint'(HOLD_CYC)   >= (longint'(1) << CNT_W) ||
       longint'(REPEAT_CYC) >= (longint'(1) << CNT_W)) begin : g_param_check
      $error("button_repeat: need HOLD_CYC>=2, REPEAT_CYC>=2, both < 2**CNT_W");
   end

   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [7:0]       RPT_MAX     = 8'hFF;

   typedef enum logic [1:0] {
      IDLE,
      PRESSED,
      REPEATING
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             press_q, press_d;
   logic             rel_q,   rel_d;
   logic             rep_q,   rep_d;
   logic             long_q,  long_d;
   logic [7:0]       rpt_q,   rpt_d;

   // Next-state and next-output logic. Release is tested before the
   // terminal count, so a release edge never also emits a repeat.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      rep_d   = 1'b0;
      long_d  = long_q;
      rpt_d   = rpt_q;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (btn.i_level) begin
               state_d = PRESSED;
               press_d = 1'b1;
               long_d  = 1'b0;
               rpt_d   = '0;
            end
         end

         PRESSED: begin
            if (!btn.i_level) begin
               state_d = IDLE;
               rel_d   = 1'b1;
               cnt_d   = '0;
            end else if (cnt_q == HOLD_LAST) begin
               state_d = REPEATING;
               cnt_d   = '0;
               long_d  = 1'b1;
               rep_d   = 1'b1;
               if (rpt_q != RPT_MAX) rpt_d = rpt_q + 8'd1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         REPEATING: begin
            if (!btn.i_level) begin
               state_d = IDLE;
               rel_d   = 1'b1;
               long_d  = 1'b0;
               cnt_d   = '0;
            end else if (cnt_q == REPEAT_LAST) begin
               cnt_d = '0;
               rep_d = 1'b1;
               if (rpt_q != RPT_MAX) rpt_d = rpt_q + 8'd1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            long_d  = 1'b0;
         end
      endcase
   end

   // State, counter and registered outputs. Reset drops any hold in
   // progress silently, so no release event is produced for it.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
         rep_q   <= 1'b0;
         long_q  <= 1'b0;
         rpt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
         rel_q   <= rel_d;
         rep_q   <= rep_d;
         long_q  <= long_d;
         rpt_q   <= rpt_d;
      end
   end

   assign btn.o_press   = press_q;
   assign btn.o_release = rel_q;
   assign btn.o_repeat  = rep_q;
   assign btn.o_long    = long_q;
   assign btn.o_rpt_cnt = rpt_q;

endmodule

// File: tb/tb_button_repeat.sv
// Bench for button_repeat with HOLD_CYC=8, REPEAT_CYC=4. The reference
// model tracks how many cycles the button has been held since the press.
// From that count it derives every expected output using plain arithmetic.
module tb_button_repeat;

   localparam int HOLD   = 8;
   localparam int REPEAT = 4;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   button_repeat_if btn ();

   button_repeat #(
      .HOLD_CYC   (HOLD),
      .REPEAT_CYC (REPEAT),
      .CNT_W      (8)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .btn   (btn.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   bit m_holding;
   int m_k;
   int m_nrep;
   bit e_press, e_rel, e_rep, e_long;
   int e_cnt;

   function automatic logic [11:0] obs_vec();
      return {btn.o_press, btn.o_release, btn.o_repeat, btn.o_long, btn.o_rpt_cnt};
   endfunction

   function automatic logic [11:0] exp_vec();
      return {e_press, e_rel, e_rep, e_long, 8'(e_cnt)};
   endfunction

   task automatic model_reset();
      m_holding = 0; m_k = 0; m_nrep = 0;
      e_press = 0; e_rel = 0; e_rep = 0; e_long = 0; e_cnt = 0;
   endtask

   task automatic model_step(input logic lvl);
      e_press = 0; e_rel = 0; e_rep = 0;
      if (lvl && !m_holding) begin
         m_holding = 1; m_k = 0; m_nrep = 0; e_press = 1; e_long = 0;
      end else if (lvl) begin
         m_k++;
         if (m_k >= HOLD && (m_k - HOLD) % REPEAT == 0) begin
            e_rep = 1;
            m_nrep++;
         end
         e_long = (m_k >= HOLD);
      end else if (m_holding) begin
         m_holding = 0; e_rel = 1; e_long = 0;
      end
      e_cnt = (m_nrep > 255) ? 255 : m_nrep;
   endtask

   // One clock: drive the level, let the edge sample it, settle 1 time unit
   task automatic drive_cycle(input logic lvl);
      btn.i_level = lvl;
      @(posedge clk);
      model_step(lvl);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      btn.i_level = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (obs_vec() !== 12'h000) begin
         failures++;
         $display("[TB] FAIL reset_values got=%b exp=%b", obs_vec(), 12'h000);
      end
      btn.i_level = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (obs_vec() !== 12'h000) begin
         failures++;
         $display("[TB] FAIL reset_dominates_level got=%b exp=%b", obs_vec(), 12'h000);
      end
      btn.i_level = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b0);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("[TB] FAIL idle_after_reset cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_short_press();
      for (int i = 0; i < 9; i++) begin
         drive_cycle(i < 5);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("[TB] FAIL short_press cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
         end
      end
      checks++;
      if (btn.o_rpt_cnt !== 8'd0 || btn.o_long !== 1'b0) begin
         failures++;
         $display("[TB] FAIL short_press_final got cnt=%0d long=%b exp cnt=0 long=0",
                  btn.o_rpt_cnt, btn.o_long);
      end
   endtask

   task automatic test_long_hold();
      for (int i = 0; i < 24; i++) begin
         drive_cycle(i < 21);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("[TB] FAIL long_hold cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
         end
      end
      checks++;
      if (btn.o_rpt_cnt !== 8'd4) begin
         failures++;
         $display("[TB] FAIL long_hold_count got=%0d exp=4", btn.o_rpt_cnt);
      end
   endtask

   task automatic test_release_on_terminal();
      for (int i = 0; i < 8; i++) drive_cycle(1'b1);
      drive_cycle(1'b0);
      checks++;
      if ({btn.o_release, btn.o_repeat, btn.o_rpt_cnt} !== {1'b1, 1'b0, 8'd0}) begin
         failures++;
         $display("[TB] FAIL release_on_terminal got rel=%b rep=%b cnt=%0d exp rel=1 rep=0 cnt=0",
                  btn.o_release, btn.o_repeat, btn.o_rpt_cnt);
      end
      drive_cycle(1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
         failures++;
         $display("[TB] FAIL release_on_terminal_after got=%b exp=%b", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_glitch();
      drive_cycle(1'b1);
      checks++;
      if ({btn.o_press, btn.o_release} !== 2'b10) begin
         failures++;
         $display("[TB] FAIL glitch_press got p/r=%b%b exp 10", btn.o_press, btn.o_release);
      end
      drive_cycle(1'b0);
      checks++;
      if ({btn.o_press, btn.o_release} !== 2'b01) begin
         failures++;
         $display("[TB] FAIL glitch_release got p/r=%b%b exp 01", btn.o_press, btn.o_release);
      end
      drive_cycle(1'b0);
   endtask

   task automatic test_reset_mid_repeat();
      for (int i = 0; i < 11; i++) drive_cycle(1'b1);
      rst = 1'b1;
      #1;
      checks++;
      if (obs_vec() !== 12'h000) begin
         failures++;
         $display("[TB] FAIL reset_mid_repeat_immediate got=%b exp=%b", obs_vec(), 12'h000);
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (obs_vec() !== 12'h000) begin
         failures++;
         $display("[TB] FAIL reset_mid_repeat_held got=%b exp=%b", obs_vec(), 12'h000);
      end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         drive_cycle(1'b1);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("[TB] FAIL reset_mid_repeat_after cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
         end
      end
      drive_cycle(1'b0);
      drive_cycle(1'b0);
   endtask

   task automatic test_saturation();
      int reps;
      reps = 0;
      for (int i = 0; i < HOLD + REPEAT * 300; i++) begin
         drive_cycle(1'b1);
         if (btn.o_repeat === 1'b1) reps++;
         checks++;
         if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("[TB] FAIL saturation cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
         end
      end
      checks++;
      if (btn.o_rpt_cnt !== 8'd255 || reps != 300) begin
         failures++;
         $display("[TB] FAIL saturation_final got cnt=%0d reps=%0d exp cnt=255 reps=300",
                  btn.o_rpt_cnt, reps);
      end
      drive_cycle(1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
         failures++;
         $display("[TB] FAIL saturation_release got=%b exp=%b", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_random();
      logic lvl;
      int   run;
      lvl = 1'b0;
      run = 0;
      for (int i = 0; i < 800; i++) begin
         if (run == 0) begin
            lvl = ~lvl;
            run = lvl ? int'($urandom_range(1, 30)) : int'($urandom_range(1, 6));
         end
         run--;
         drive_cycle(lvl);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("[TB] FAIL random cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
         end
         checks++;
         if (!$onehot0({btn.o_press, btn.o_release, btn.o_repeat})) begin
            failures++;
            $display("[TB] FAIL random_pulse_overlap cyc=%0d got p/r/rep=%b%b%b exp at most one high",
                     i, btn.o_press, btn.o_release, btn.o_repeat);
         end
         if ($urandom_range(0, 49) == 0) begin
            rst = 1'b1;
            #1;
            checks++;
            if (obs_vec() !== 12'h000) begin
               failures++;
               $display("[TB] FAIL random_reset cyc=%0d got=%b exp=%b", i, obs_vec(), 12'h000);
            end
            @(negedge clk);
            rst = 1'b0;
            model_reset();
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      btn.i_level = 1'b0;
      test_reset();
      test_short_press();
      test_long_hold();
      test_release_on_terminal();
      test_glitch();
      test_reset_mid_repeat();
      test_saturation();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
